// File: rtl/pcie_sq_wrr_sched.sv
// pcie_sq_wrr_sched
//   Submission-queue fetch arbiter. Picks one queue whose fetch pointer lags
//   its doorbell tail, using strict priority for the admin queue and weighted
//   round-robin (bursts of weight+1) across the eight IO queues. It then
//   presents one fetch grant (queue id, entry index, host DWORD address) and
//   holds it until the requester acknowledges it.
//
// Ports
//   pcie_user_clk   sole clock
//   pcie_user_rst   synchronous active-high reset
//   sq_valid[8:0]   queue enabled (bit 0 admin, bits 1..8 io_sq1..8)
//   sq_rst_n[8:0]   per-queue soft reset, active-low (clears fetch pointer)
//   sq_size         8 bits per queue, entries-1
//   sq_tail_ptr     8 bits per queue, doorbell tail
//   sq_bs_addr      (C_PCIE_ADDR_WIDTH-2) bits per queue, DWORD base address
//   io_sq_weight    2 bits per IO queue; burst length = weight+1
//   arb_sq_rdy      grant valid
//   sq_qid          granted queue id
//   sq_fetch_ptr    entry index being fetched
//   hcmd_pcie_addr  host DWORD address of that entry
//   sq_hcmd_ack     requester consumed the grant
module pcie_sq_wrr_sched #(
  parameter int C_PCIE_ADDR_WIDTH = 48
) (
  input  logic                                 pcie_user_clk,
  input  logic                                 pcie_user_rst,
  input  logic [8:0]                           sq_valid,
  input  logic [8:0]                           sq_rst_n,
  input  logic [71:0]                          sq_size,
  input  logic [71:0]                          sq_tail_ptr,
  input  logic [9*(C_PCIE_ADDR_WIDTH-2)-1:0]   sq_bs_addr,
  input  logic [15:0]                          io_sq_weight,
  output logic                                 arb_sq_rdy,
  output logic [3:0]                           sq_qid,
  output logic [7:0]                           sq_fetch_ptr,
  output logic [C_PCIE_ADDR_WIDTH-1:2]         hcmd_pcie_addr,
  input  logic                                 sq_hcmd_ack
);

  localparam int AW = C_PCIE_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_ADDR,
    S_REQ
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      fptr_q [9];
  logic [8:0]      pending;
  logic [3:0]      sel_q, sel_d;     // queue chosen in SELECT
  logic            rot_q, rot_d;     // chosen by rotation (new burst)
  logic [3:0]      last_q, last_d;   // last IO queue that completed a grant
  logic [2:0]      burst_q, burst_d; // grants completed in the current burst
  logic            rdy_q, rdy_d;
  logic [3:0]      qid_q, qid_d;
  logic [7:0]      ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            ack_take;

  logic [1:0]      w_last;
  logic            rr_found;
  logic [3:0]      rr_q;
  logic [7:0]      sel_fptr;
  logic [AW-1:0]   sel_base;
  logic            sel_ok;

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      pending[i] = sq_valid[i] & sq_rst_n[i] & (fptr_q[i] != sq_tail_ptr[8*i +: 8]);
    end
  end

  always_comb begin
    w_last = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (last_q == 4'(k)) w_last = io_sq_weight[2*(k-1) +: 2];
    end
  end

  // Rotation scans the eight IO queues starting just after last_q; last_q
  // itself is the final candidate so a lone pending queue still gets a burst.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    rr_found = 1'b0;
    rr_q     = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      cand = ((32'(last_q) + k - 1) % 8) + 1;
      if (!rr_found && pending[cand[3:0]]) begin
        rr_found = 1'b1;
        rr_q     = cand[3:0];
      end
    end
  end

  always_comb begin
    sel_fptr = '0;
    sel_base = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (sel_q == 4'(i)) begin
        sel_fptr = fptr_q[i];
        sel_base = sq_bs_addr[AW*i +: AW];
      end
    end
  end

  assign sel_ok = sq_valid[sel_q] & sq_rst_n[sel_q];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rot_d    = rot_q;
    last_d   = last_q;
    burst_d  = burst_q;
    rdy_d    = rdy_q;
    qid_d    = qid_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    ack_take = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|pending) state_d = S_SELECT;
      end
      S_SELECT: begin
        state_d = S_ADDR;
        if (pending[0]) begin
          sel_d = 4'd0;
          rot_d = 1'b0;
        end else if (pending[last_q] && (burst_q <= {1'b0, w_last})) begin
          sel_d = last_q;
          rot_d = 1'b0;
        end else if (rr_found) begin
          sel_d = rr_q;
          rot_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (!sel_ok) begin
          state_d = S_IDLE;
        end else begin
          qid_d   = sel_q;
          ptr_d   = sel_fptr;
          addr_d  = sel_base + AW'({sel_fptr, 4'b0000});
          rdy_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!sel_ok) begin
          rdy_d   = 1'b0;
          state_d = S_IDLE;
        end else if (sq_hcmd_ack) begin
          ack_take = 1'b1;
          rdy_d    = 1'b0;
          state_d  = S_IDLE;
          // Burst bookkeeping is committed only on a completed grant, so a
          // dropped grant leaves the round-robin position untouched.
          if (sel_q != 4'd0) begin
            last_d  = sel_q;
            burst_d = rot_q ? 3'd1 : burst_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rot_q   <= 1'b0;
      last_q  <= 4'd8;
      burst_q <= '0;
      rdy_q   <= 1'b0;
      qid_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rot_q   <= rot_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rdy_q   <= rdy_d;
      qid_q   <= qid_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    for (int unsigned i = 0; i < 9; i++) begin
      if (pcie_user_rst || !sq_rst_n[i]) begin
        fptr_q[i] <= '0;
      end else if (ack_take && (sel_q == 4'(i))) begin
        fptr_q[i] <= (fptr_q[i] == sq_size[8*i +: 8]) ? '0 : fptr_q[i] + 8'd1;
      end
    end
  end

  assign arb_sq_rdy     = rdy_q;
  assign sq_qid         = qid_q;
  assign sq_fetch_ptr   = ptr_q;
  assign hcmd_pcie_addr = addr_q;

endmodule

// File: doc/pcie_sq_wrr_sched.md
PCIE_SQ_WRR_SCHED -- requirements
Module: pcie_sq_wrr_sched

Interface
REQ-001 The block SHALL have the parameter C_PCIE_ADDR_WIDTH, default 48, which sets the host address width; addresses are DWORD-aligned as bits [C_PCIE_ADDR_WIDTH-1:2].
REQ-002 The block SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
- pcie_user_clk  in  1  sole clock.
- pcie_user_rst  in  1  synchronous, active-high block reset.
- sq_valid  in  9  queue enabled; bit 0 = admin, bits 1..8 = io_sq1..8.
- sq_rst_n  in  9  per-queue soft reset, active-low.
- sq_size  in  72  queue i at [8i+7:8i]; zero-based (number of entries - 1).
- sq_tail_ptr  in  72  doorbell tail of queue i at [8i+7:8i].
- sq_bs_addr  in  9*(C_PCIE_ADDR_WIDTH-2)  base address of queue i in slice i.
- io_sq_weight  in  16  2-bit burst weight of io_sq(k) at [2k-1:2k-2]; burst = weight+1.
- arb_sq_rdy  out  1  a fetch grant is valid.
- sq_qid  out  4  granted queue id, 0..8.
- sq_fetch_ptr  out  8  entry index being fetched.
- hcmd_pcie_addr  out  C_PCIE_ADDR_WIDTH-2  host DWORD address of that entry.
- sq_hcmd_ack  in  1  requester consumed the grant.

Function
REQ-004 The block SHALL keep one 8-bit fetch pointer fptr[i] per queue.
REQ-005 Queue i SHALL be pending when sq_valid[i]=1, sq_rst_n[i]=1 and fptr[i]!=tail[i].
REQ-006 The state machine SHALL have the states IDLE, SELECT, ADDR and REQ.
REQ-007 IDLE SHALL move to SELECT on the first cycle in which any queue is pending; otherwise it stays in IDLE.
REQ-008 SELECT SHALL choose the queue by the following rules:
- admin (qid 0) whenever it is pending: strict priority;
- else the last-granted IO queue, if it is still pending and its burst count is below weight+1;
- else the next pending IO queue in round-robin order after the last-granted IO queue (1..8 wrapping to 1), with the burst count reset to 0;
- if no queue is pending, return to IDLE.
REQ-009 ADDR SHALL register sq_qid, sq_fetch_ptr=fptr[q] and hcmd_pcie_addr = bs_addr[q] + {fptr[q],4'b0000} (64-byte entry = 16 DW), truncated to C_PCIE_ADDR_WIDTH-2 bits, and then go to REQ.
REQ-010 In REQ, arb_sq_rdy SHALL be 1, and sq_qid, sq_fetch_ptr and hcmd_pcie_addr SHALL hold stable until sq_hcmd_ack.
REQ-011 Latency from a pending queue in IDLE to arb_sq_rdy=1 SHALL be exactly 3 cycles.
REQ-012 On sq_hcmd_ack in REQ, the block SHALL:
- set fptr[q] to 0 if fptr[q]==sq_size[q], else to fptr[q]+1;
- increment the burst count for an IO queue;
- record the last-granted IO queue;
- deassert arb_sq_rdy in the next cycle;
- go to IDLE.
REQ-013 sq_hcmd_ack outside REQ SHALL be ignored.
REQ-014 At most one grant SHALL be outstanding; no back-to-back grants occur without IDLE in between.
REQ-015 sq_rst_n[i]=0 SHALL force fptr[i] to 0 on every cycle it is low; this takes priority over a same-cycle ack increment.
REQ-016 If sq_rst_n[q]=0 or sq_valid[q]=0 for the granted queue during ADDR or REQ, the block SHALL:
- drop the grant (arb_sq_rdy=0 next cycle);
- not increment the pointer;
- return to IDLE.
REQ-017 Changes to tail pointers or weights SHALL take effect at the next SELECT; a tail written behind fptr SHALL be treated only by inequality (no full/overrun detection).
REQ-018 io_sq_weight SHALL be sampled at SELECT; a weight lowered below the current burst count forces rotation.

Reset
REQ-019 On pcie_user_rst=1 the block SHALL set:
- state = IDLE;
- all fptr = 0;
- burst count = 0;
- last-granted IO queue = 8, so the first IO grant goes to io_sq1;
- arb_sq_rdy = 0, sq_qid = 0, sq_fetch_ptr = 0, hcmd_pcie_addr = 0.
REQ-020 pcie_user_rst asserted in any state SHALL abort the grant at the next edge, with no pointer increment.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Admin only: sq_size[0]=3, tail0=2, base 0x1000 (DW) -> two grants with qid 0, ptr 0 then 1, addr 0x1000 then 0x1010; arb_sq_rdy 3 cycles after pending; then idle.
- Wrap: size=3, fptr at 3, tail=1 -> grants with ptr 3 then 0; fptr ends at 1.
- WRR: io_sq1 and io_sq2 each hold 4 pending, weights 1 and 0 -> qid order 1,1,2,1,1,2,2,2.
- Admin preemption: io_sq3 mid-burst (weight 3), admin tail bumped -> the next grant is qid 0, then io_sq3 resumes its burst.
- Soft reset mid-REQ: sq_rst_n[2]=0 while qid 2 is granted, together with ack -> arb_sq_rdy=0 next cycle, fptr[2]=0, no grant to qid 2 until sq_rst_n[2]=1.
- Block reset during REQ -> all outputs 0 the next cycle, all fptr 0.
